ula_seq: RTL and testbench
==========================

// Module: ula_seq
// PURPOSE
// Parametrised, registered successor to the 8-bit combinational ULA.
// - Width is a parameter.
// - Opcode set is extended, and a multi-cycle shift-add multiplier is added.
// - Produces status flags.
// - Uses valid/ready handshakes on input and output.
// - Sits between the operand/register stage and the writeback stage of the datapath.
// PARAMETERS
// WIDTH    8   operand/result width in bits (>=2)
// CNT_W    4   multiply iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
// clk        in   1      rising-edge clock
// rst_n      in   1      asynchronous reset, active low
// in_valid   in   1      operands and opcode are valid
// in_ready   out  1      block can accept an operation
// op         in   4      opcode (see BEHAVIOUR)
// a          in   WIDTH  operand A
// b          in   WIDTH  operand B
// out_valid  out  1      result/flags valid
// out_ready  in   1      consumer accepts result
// result     out  WIDTH  result, low half for MUL
// result_hi  out  WIDTH  MUL high half; 0 for all other ops
// flag_z     out  1      result==0 (low half only)
// flag_n     out  1      result[WIDTH-1]
// flag_c     out  1      carry / no-borrow / shifted-out bit / |result_hi
// flag_v     out  1      two's-complement overflow (ADD/SUB only)
// BEHAVIOUR
// - Clock/reset: one clock domain, clk; reset rst_n is asynchronous and active-low.
// - Reset clears all registers: FSM->IDLE, in_ready=1, out_valid=0, result=0, result_hi=0,
//   all flags=0. Reset mid-MUL aborts; no partial result ever appears.
// - FSM states:
//   - IDLE: in_ready=1, out_valid=0. Transfer on in_valid&&in_ready.
//     - Non-MUL op -> DONE.
//     - MUL -> MUL, latching a and b, clearing the accumulator, cnt=0.
//   - MUL: in_ready=0. Each cycle: if mult[0], acc_hi += mcand. Then {acc_hi,acc_lo} >>= 1, cnt++.
//     After WIDTH iterations -> DONE.
//   - DONE: out_valid=1, outputs held stable. On out_ready -> IDLE.
// - Latency: accept edge k. Non-MUL: out_valid high after edge k+1. MUL: after edge k+1+WIDTH.
//   Max throughput 1 op / 2 cycles.
// - Output stability: outputs are registered and change only on the DONE entry edge.
//   While out_valid && !out_ready they must not change.
// - Opcodes:
//   - 0 ADD  a+b.           c=carry-out.   v=signed overflow.
//   - 1 SUB  a+~b+1.        c=no-borrow (a>=b unsigned).   v=signed overflow.
//   - 2 AND, 3 OR, 4 XOR, 5 NOT a.   c=0, v=0.
//   - 6 SHL  a<<1.   c=a[WIDTH-1].   v=0.
//   - 7 SHR  a>>1 logical.   c=a[0].   v=0.
//   - 8 MUL  unsigned a*b.   {result_hi,result}=2*WIDTH-bit product.   c=|result_hi.   v=0.
//   - 9-15: result=0, z=1, c=0, v=0. Still handshaked like any other op.
// - Width rules: ADD/SUB are computed in WIDTH+1 bits; the MSB is carry. MUL accumulator is
//   WIDTH+1 bits to hold the add carry.
// - Simultaneous events: in_valid arriving in DONE or MUL is ignored (in_ready=0); the source
//   must hold it. out_ready with !out_valid has no effect.
// TESTING
// 1. WIDTH=8, ADD a=FF b=01 -> one cycle later result=00, z=1, c=1, v=0, n=0.
// 2. SUB a=80 b=01 -> result=7F, c=1, v=1, n=0.
//    SUB a=01 b=02 -> result=FF, c=0, n=1.
// 3. MUL a=0F b=11 -> out_valid exactly 9 cycles after accept; result=FF, result_hi=00, c=0.
//    MUL a=FF b=FF -> result_hi=FE, result=01, c=1.
// 4. Backpressure: hold out_ready=0 for 5 cycles after ADD 03+04 -> result=07 stable,
//    out_valid=1, in_ready=0. Release -> IDLE next cycle, in_ready=1.
// 5. Reset mid-MUL (deassert rst_n at iteration 3) -> all outputs 0 immediately, in_ready=1.
//    Next MUL 02*03 -> result=06.
// 6. Opcode 0xC with a=AA -> result=00, z=1. Then SHL AA -> result=54, c=1.
//    Then SHR 01 -> result=00, z=1, c=1.

Source files
------------

// File: rtl/ula_seq_if.sv
// rtl/ula_seq_if.sv - operand/result handshake bundle for ula_seq
interface ula_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi, flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, result_hi, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - registered ALU with flags and a shift-add multiplier
module ula_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  ula_seq_if.slave   bus
);
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             mul_last;

  // WIDTH+1 bits so the add carry survives into the shift
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt;
  logic [WIDTH-1:0] mul_lo_nxt;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  assign accept   = (state == S_IDLE) && bus.in_valid;
  assign mul_last = (state == S_MUL) && (cnt == CNT_W'(WIDTH - 1));

  // acc_lo starts as the multiplier; its LSB selects the add, then the pair shifts right
  assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
  assign mul_hi_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};

  assign add_w = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_w = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);

  // single-cycle opcodes, evaluated on the live operands at the accept edge
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      4'd0: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'd1: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'd2: alu_res = bus.a & bus.b;
      4'd3: alu_res = bus.a | bus.b;
      4'd4: alu_res = bus.a ^ bus.b;
      4'd5: alu_res = ~bus.a;
      4'd6: begin
        alu_res = {bus.a[WIDTH-2:0], 1'b0};
        alu_c   = bus.a[WIDTH-1];
      end
      4'd7: begin
        alu_res = {1'b0, bus.a[WIDTH-1:1]};
        alu_c   = bus.a[0];
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.in_valid) state_nxt = (bus.op == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:   if (mul_last) state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM handshake outputs
  always_comb begin
    bus.in_ready  = (state == S_IDLE);
    bus.out_valid = (state == S_DONE);
  end

  // multiplier working registers: latch operands on accept, iterate while in MUL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (accept && bus.op == OP_MUL) begin
      mcand  <= bus.a;
      acc_hi <= '0;
      acc_lo <= bus.b;
      cnt    <= '0;
    end else if (state == S_MUL) begin
      acc_hi <= mul_hi_nxt;
      acc_lo <= mul_lo_nxt;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // result/flag registers only load on the edge that enters DONE, so they hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result    <= '0;
      bus.result_hi <= '0;
      bus.flag_z    <= 1'b0;
      bus.flag_n    <= 1'b0;
      bus.flag_c    <= 1'b0;
      bus.flag_v    <= 1'b0;
    end else if (accept && bus.op != OP_MUL) begin
      bus.result    <= alu_res;
      bus.result_hi <= '0;
      bus.flag_z    <= (alu_res == '0);
      bus.flag_n    <= alu_res[WIDTH-1];
      bus.flag_c    <= alu_c;
      bus.flag_v    <= alu_v;
    end else if (mul_last) begin
      bus.result    <= mul_lo_nxt;
      bus.result_hi <= mul_hi_nxt;
      bus.flag_z    <= (mul_lo_nxt == '0);
      bus.flag_n    <= mul_lo_nxt[WIDTH-1];
      bus.flag_c    <= |mul_hi_nxt;
      bus.flag_v    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ula_seq.sv
// tb/tb_ula_seq.sv - randomized self-checking bench for ula_seq
module tb_ula_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ula_seq_if #(.WIDTH(W)) bus ();

  ula_seq #(.WIDTH(W), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference behaviour from plain integer arithmetic
  task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic [7:0] rh,
                       output logic z, output logic n, output logic c, output logic v);
    int ua, ub, sa, sb, full;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    r = 8'h00; rh = 8'h00; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin full = ua + ub; r = 8'(full); c = full > 255; v = (sa + sb > 127) || (sa + sb < -128); end
      4'd1: begin r = 8'(ua - ub); c = ua >= ub; v = (sa - sb > 127) || (sa - sb < -128); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = 8'(ua * 2); c = ua >= 128; end
      4'd7: begin r = 8'(ua / 2); c = (ua % 2) == 1; end
      4'd8: begin full = ua * ub; r = 8'(full); rh = 8'(full / 256); c = rh != 0; end
      default: ;
    endcase
    z = (r == 8'h00);
    n = r[7];
  endtask

  task automatic check_outs(input string t, input logic [7:0] r, input logic [7:0] rh,
                            input logic z, input logic n, input logic c, input logic v);
    check({t, ".res"}, bus.result, r);
    check({t, ".hi"},  bus.result_hi, rh);
    check({t, ".z"},   bus.flag_z, z);
    check({t, ".n"},   bus.flag_n, n);
    check({t, ".c"},   bus.flag_c, c);
    check({t, ".v"},   bus.flag_v, v);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input int stall);
    logic [7:0] er, erh;
    logic ez, en, ec, ev;
    int lat;
    string t;
    t = $sformatf("op%0h_%02h_%02h", op, a, b);
    model(op, a, b, er, erh, ez, en, ec, ev);
    lat = 0;
    while (!bus.in_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({t, ".in_ready"}, bus.in_ready, 1'b1);
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    bus.op = 4'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 50);
    check({t, ".latency"}, lat, (op == 4'd8) ? 9 : 1);
    check_outs(t, er, erh, ez, en, ec, ev);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({t, ".hold_valid"}, bus.out_valid, 1'b1);
      check({t, ".hold_ready"}, bus.in_ready, 1'b0);
      check_outs({t, ".hold"}, er, erh, ez, en, ec, ev);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({t, ".ret_ready"}, bus.in_ready, 1'b1);
    check({t, ".ret_valid"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = 4'd0; bus.a = 8'h00; bus.b = 8'h00;
    #12;
    check("rst.in_ready", bus.in_ready, 1'b1);
    check("rst.out_valid", bus.out_valid, 1'b0);
    check_outs("rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(4'd0, 8'hFF, 8'h01, 0);
    do_op(4'd1, 8'h80, 8'h01, 0);
    do_op(4'd1, 8'h01, 8'h02, 0);
    do_op(4'd8, 8'h0F, 8'h11, 0);
    do_op(4'd8, 8'hFF, 8'hFF, 1);
    do_op(4'd0, 8'h03, 8'h04, 5);
    do_op(4'd0, 8'h7F, 8'h01, 0);

    // reset in the middle of a multiply
    bus.op = 4'd8; bus.a = 8'hFF; bus.b = 8'hFE; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.in_ready", bus.in_ready, 1'b1);
    check("midrst.out_valid", bus.out_valid, 1'b0);
    check_outs("midrst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst.no_result", bus.out_valid, 1'b0);

    do_op(4'd8, 8'h02, 8'h03, 0);
    do_op(4'hC, 8'hAA, 8'h00, 0);
    do_op(4'd6, 8'hAA, 8'h00, 0);
    do_op(4'd7, 8'h01, 8'h00, 0);

    for (int k = 0; k < 60; k++) begin
      do_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
